// File: rtl/wide_add_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wide_add_seq                                               |
// | Description : Computes an N*WORDS-bit sum by time-multiplexing a single  |
// |               external N-bit adder, one word per clock, LSW first, with  |
// |               the carry chained word to word. Start/busy/done host       |
// |               handshake.                                                 |
// |               Optional macro WIDE_ADD_SUB_EN adds a 'sub' input that     |
// |               turns an accepted request into A-B (cout=1: no borrow).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wide_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic                 cout,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_ci,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_co
`ifdef WIDE_ADD_SUB_EN
  ,
  input  logic                 sub
`endif
);

  localparam int W  = N * WORDS;
  // Index counter is kept at least one bit wide so WORDS=1 still elaborates.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic            r_cout;

  logic            w_accept;
  logic            w_last;
  logic [W-1:0]    w_b_load;
  logic            w_carry_load;
  logic [N-1:0]    w_add_a;
  logic [N-1:0]    w_add_b;
  logic            w_add_ci;

  // A request is only honoured when the sequencer is not mid-operation.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_idx == C_LAST_IDX);

  // Operand B / initial carry as loaded on accept; subtraction is A + ~B + 1.
`ifdef WIDE_ADD_SUB_EN
  assign w_b_load     = sub ? ~op_b : op_b;
  assign w_carry_load = sub ? 1'b1  : cin;
`else
  assign w_b_load     = op_b;
  assign w_carry_load = cin;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: RUN for exactly WORDS cycles, DONE for one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Word select toward the shared adder; parked at zero outside RUN.
  always_comb begin
    w_add_a  = '0;
    w_add_b  = '0;
    w_add_ci = 1'b0;
    if (r_state == S_RUN) begin
      w_add_ci = r_carry;
      for (int k = 0; k < WORDS; k++) begin
        if (r_idx == IW'(k)) begin
          w_add_a = r_a[k*N +: N];
          w_add_b = r_b[k*N +: N];
        end
      end
    end
  end

  // Operand capture on accept, then per-word result/carry update during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= w_b_load;
      r_carry <= w_carry_load;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      for (int k = 0; k < WORDS; k++) begin
        if (r_idx == IW'(k)) begin
          r_result[k*N +: N] <= add_sum;
        end
      end
      r_carry <= add_co;
      if (w_last) begin
        // Index holds at the last word; the next accept reloads it.
        r_cout <= add_co;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign add_a  = w_add_a;
  assign add_b  = w_add_b;
  assign add_ci = w_add_ci;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wide_add_seq                                            |
// | Description : Scoreboard bench for wide_add_seq with a behavioural       |
// |               external adder and an arithmetic reference model.          |
// |               Exercises subtraction when WIDE_ADD_SUB_EN is defined.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wide_add_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    int           done_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          busy, done, cout, add_ci, add_co;
  logic [W-1:0]  result;
  logic [N-1:0]  add_a, add_b, add_sum;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared N-bit adder.
  logic [N:0] w_add_full;
  assign w_add_full = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_ci};
  assign add_sum    = w_add_full[N-1:0];
  assign add_co     = w_add_full[N];

  wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_sum(add_sum),
    .add_co(add_co)
`ifdef WIDE_ADD_SUB_EN
    , .sub(sub)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic, subtraction as modular difference.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s, input int dc);
    exp_t e;
    logic [W:0] full;
    if (s) begin
      full = {1'b0, a} - {1'b0, b};
      e.res = full[W-1:0];
      e.co  = (a >= b);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.res = full[W-1:0];
      e.co  = full[W];
    end
    e.done_cyc = dc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("cout", 64'(cout), 64'(e.co));
          chk("done_latency", 64'(cyc), 64'(e.done_cyc));
        end
        chk("busy_with_done", 64'(busy), 64'd0);
      end
      if (!busy) begin
        chk("adder_idle_zero", {add_a, add_b, add_ci}, 64'd0);
      end
    end
  end

  // Issue one op from a negedge; returns once the DUT has left RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    int guard;
    guard = 0;
    while (busy && guard < 50) begin @(negedge clk); guard++; end
    start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
    q.push_back(model(a, b, c, s, cyc + 1 + WORDS));
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (busy && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin @(negedge clk); guard++; end
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           e0;

    // Reset state.
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_adder", {add_a, add_b, add_ci}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 1) basic add with carries rippling across words.
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    drain();

    // 2) all-ones plus carry-in: add_ci must be 1 on every RUN cycle.
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'h0000; cin = 1'b1; sub = 1'b0;
    q.push_back(model(16'hFFFF, 16'h0000, 1'b1, 1'b0, cyc + 1 + WORDS));
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      chk("t2_busy", 64'(busy), 64'd1);
      chk("t2_add_ci", 64'(add_ci), 64'd1);
      chk("t2_add_a", 64'(add_a), 64'hF);
      @(negedge clk);
    end
    drain();

    // Result holds while idle.
    repeat (3) @(negedge clk);
    chk("idle_hold_result", 64'(result), 64'h0000);
    chk("idle_hold_cout", 64'(cout), 64'd1);

    // 3) start during RUN is ignored.
    start = 1'b1; op_a = 16'h0101; op_b = 16'h0202; cin = 1'b0; sub = 1'b0;
    q.push_back(model(16'h0101, 16'h0202, 1'b0, 1'b0, cyc + 1 + WORDS));
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t3_busy_kept", 64'(busy), 64'd1);
    drain();

    // 4) asynchronous reset during word 2 aborts everything.
    start = 1'b1; op_a = 16'h7777; op_b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_result", 64'(result), 64'd0);
    chk("t4_cout", 64'(cout), 64'd0);
    chk("t4_adder", {add_a, add_b, add_ci}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    drain();

    // 5) start held through DONE: back-to-back with no idle cycle.
    start = 1'b1; op_a = 16'h00FF; op_b = 16'h0F01; cin = 1'b0; sub = 1'b0;
    e0 = cyc + 1;
    q.push_back(model(16'h00FF, 16'h0F01, 1'b0, 1'b0, e0 + WORDS));
    @(negedge clk);
    op_a = 16'hBEEF; op_b = 16'h4111; cin = 1'b1;
    for (int k = 0; k < 20 && cyc < e0 + WORDS; k++) @(negedge clk);
    chk("t5_done_first", 64'(done), 64'd1);
    q.push_back(model(16'hBEEF, 16'h4111, 1'b1, 1'b0, e0 + WORDS + 1 + WORDS));
    @(negedge clk);
    chk("t5_busy_again", 64'(busy), 64'd1);
    start = 1'b0;
    drain();

`ifdef WIDE_ADD_SUB_EN
    // 6) subtraction, with and without borrow.
    do_op(16'h1000, 16'h0001, 1'b0, 1'b1);
    drain();
    do_op(16'h0000, 16'h0001, 1'b1, 1'b1);
    drain();
`endif

    // Randomised traffic against the reference model.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
`ifdef WIDE_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, 1'($urandom_range(0, 1)), rs);
    end
    drain();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
